// File: rtl/freq_counter.sv
// Three independent square-wave dividers off one clock: each channel toggles
// its output every HALFn cycles, giving CLK_HZ/(2*HALFn) with 50 % duty.
module freq_counter #(
   parameter int CLK_HZ = 25000000,
   parameter int F0_HZ  = 2,
   parameter int F1_HZ  = 5,
   parameter int F2_HZ  = 9
) (
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] q
);

   localparam int HALF0 = CLK_HZ / (2 * F0_HZ);
   localparam int HALF1 = CLK_HZ / (2 * F1_HZ);
   localparam int HALF2 = CLK_HZ / (2 * F2_HZ);

   for (genvar n = 0; n < 3; n++) begin : g_ch
      localparam int H = (n == 0) ? HALF0 : ((n == 1) ? HALF1 : HALF2);
      localparam int W = (H > 1) ? $clog2(H) : 1;
      localparam logic [W-1:0] LAST = W'(H - 1);

      if (H < 1) begin : g_bad_ratio
         $error("freq_counter: half period of channel %0d is below one clock", n);
      end

      logic [W-1:0] cnt_q;
      logic [W-1:0] cnt_d;
      logic         tog_q;
      logic         tog_d;

      // Terminal count wraps the counter and flips the output.
      always_comb begin
         cnt_d = cnt_q;
         tog_d = tog_q;
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tog_d = ~tog_q;
         end else begin
            cnt_d = cnt_q + W'(1'b1);
            tog_d = tog_q;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
         end
      end

      assign q[n] = tog_q;
   end

endmodule

// File: tb/tb_freq_counter.sv
// Random-reset bench for freq_counter: outputs are predicted from the number of
// clock edges since reset release, q[n] = floor(k / HALFn) mod 2.
module tb_freq_counter;

   logic       clk;
   logic       reset;
   logic [2:0] q;
   logic [2:0] q_deg;
   logic [2:0] q_def;

   int total = 0;
   int bad   = 0;
   int k     = 0;
   int last_t [3];
   logic [2:0] prev;
   localparam int HS [3] = '{25, 10, 5};

   freq_counter #(.CLK_HZ(100), .F0_HZ(2), .F1_HZ(5), .F2_HZ(9)) u_dut (
      .clk(clk), .reset(reset), .q(q)
   );

   // HALF0=2, HALF1=2, HALF2=1
   freq_counter #(.CLK_HZ(4), .F0_HZ(1), .F1_HZ(1), .F2_HZ(2)) u_deg (
      .clk(clk), .reset(reset), .q(q_deg)
   );

   freq_counter u_def (
      .clk(clk), .reset(reset), .q(q_def)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_q(input int kk, input int h0, input int h1, input int h2);
      logic [2:0] r;
      r[0] = ((kk / h0) % 2) == 1;
      r[1] = ((kk / h1) % 2) == 1;
      r[2] = ((kk / h2) % 2) == 1;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      check_eq("q", {29'd0, q}, {29'd0, ref_q(k, 25, 10, 5)});
      check_eq("q_deg", {29'd0, q_deg}, {29'd0, ref_q(k, 2, 2, 1)});
      check_eq("q_def", {29'd0, q_def}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         if (q[n] !== prev[n]) begin
            check_eq($sformatf("%s_len%0d", q[n] ? "low" : "high", n), k - last_t[n], HS[n]);
            last_t[n] = k;
         end
      end
      prev = q;
   endtask

   task automatic rst_pulse(input int off_ns, input int cycles);
      #(off_ns);
      reset = 1'b1;
      #1;
      check_eq("rst_async", {29'd0, q}, 32'd0);
      check_eq("rst_async_deg", {29'd0, q_deg}, 32'd0);
      prev = 3'b000;
      for (int n = 0; n < 3; n++) last_t[n] = 0;
      repeat (cycles) @(posedge clk);
      #6;
      check_eq("rst_hold", {29'd0, q}, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      prev  = 3'b000;
      for (int n = 0; n < 3; n++) last_t[n] = 0;
      #2 reset = 1'b1;
      #3;
      check_eq("rst_noclk", {29'd0, q}, 32'd0);
      check_eq("rst_noclk_deg", {29'd0, q_deg}, 32'd0);
      #100;
      check_eq("rst_hold0", {29'd0, q}, 32'd0);
      #5 reset = 1'b0;

      // scaled toggle timing, period and duty
      repeat (200) begin
         step();
         if (k == 4)  check_eq("edge4", {29'd0, q}, {29'd0, 3'b000});
         if (k == 5)  check_eq("edge5", {29'd0, q}, {29'd0, 3'b100});
         if (k == 10) check_eq("edge10", {29'd0, q}, {29'd0, 3'b010});
         if (k == 25) check_eq("edge25", {29'd0, q}, {29'd0, 3'b101});
      end

      // reset 7 ns after edge 37, held two clocks
      rst_pulse(6, 2);
      repeat (37) step();
      rst_pulse(6, 2);
      repeat (60) begin
         step();
         if (k == 5)  check_eq("re_edge5", {29'd0, q}, {29'd0, 3'b100});
         if (k == 10) check_eq("re_edge10", {29'd0, q}, {29'd0, 3'b010});
         if (k == 25) check_eq("re_edge25", {29'd0, q}, {29'd0, 3'b101});
      end

      // random run lengths and reset phases
      repeat (25) begin
         repeat ($urandom_range(1, 120)) step();
         rst_pulse($urandom_range(1, 37), $urandom_range(1, 3));
      end
      repeat (30) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
